sliding_window_buffer: RTL and testbench
========================================

Name: sliding_window_buffer

Overview:
- Parametrised successor to the fixed 3x3 shift-register-plus-FIFO row buffering in front of the Sobel stage.
- Accepts a one-pixel-per-`en` raster stream and emits a full WIN x WIN neighbourhood every accepted pixel, with frame/line position tracking.
- Taps falling outside the frame (above row 0, left of column 0) are forced to a border constant, so nothing from the previous line or frame leaks into them.
- Feeds sobel_window, the future 5x5 filters and connected_components_labeling (which uses WIN=2 anchored taps).

Parameters:
- DATA_WIDTH, 8, bits per pixel.
- WIN, 3, window edge length; legal 2..7.
- FRAME_WIDTH, 640, maximum pixels per line.
- ADDR_WIDTH, 11, line-memory address width; must satisfy 2^ADDR_WIDTH >= FRAME_WIDTH.
- BORDER_VALUE, 0, DATA_WIDTH-bit value substituted for out-of-frame taps.

Ports:
- clk  in  1  pixel clock.
- reset_n  in  1  asynchronous, active-low reset.
- en  in  1  pixel strobe; all state advances only when en=1.
- hsync  in  1  qualified by en; marks the first pixel of a line.
- vsync  in  1  qualified by en; marks the first pixel of a frame (also implies hsync).
- data  in  DATA_WIDTH  input pixel.
- window  out  WIN*WIN*DATA_WIDTH  tap (r,c) at bits [(r*WIN+c)*DATA_WIDTH +: DATA_WIDTH]; r=0 top (oldest) row, c=0 leftmost column.
- valid  out  1  window updated this cycle.
- interior  out  1  every tap lies inside the frame.
- x  out  16  column of the anchor pixel, tap (WIN-1,WIN-1).
- y  out  16  row of the anchor pixel.
- overrun  out  1  sticky; set when a line exceeds FRAME_WIDTH, cleared by vsync.

Behaviour:
- Reset (async assert, sync release): col=0, row=0, all outputs 0, shift registers 0. Line memories are not cleared; masking covers them. The first pixel after reset is treated as (0,0) even without vsync.
- Position counters, per en cycle:
  - vsync: col=0, row=0.
  - hsync without vsync: col=0, row=row+1, saturating at 16'hFFFF.
  - otherwise: col=col+1, saturating at 16'hFFFF.
  - hsync/vsync are ignored when en=0.
- Line memory: WIN-1 cascaded row delays, each 2^ADDR_WIDTH words, addressed by col[ADDR_WIDTH-1:0].
  - Stage k outputs the pixel at the same column from row-k.
  - Reads return the pre-write content (read-before-write in the same cycle).
  - Stage k writes what stage k-1 read, and stage 1 writes data.
- Column shift: each of the WIN rows has a WIN-deep shift register loaded from its row source on en. Column c holds source column col-(WIN-1)+c.
- Masking is applied at the output register:
  - A tap with source column < 0 (col < WIN-1-c) is forced to BORDER_VALUE.
  - A tap with source row < 0 (row < WIN-1-r) is forced to BORDER_VALUE.
- Latency: window, valid, x, y and interior are registered 1 cycle after the en cycle. Tap (WIN-1,WIN-1) equals that cycle's data.
- valid=1 exactly one cycle after each en=1, otherwise 0. window/x/y hold their values while valid=0.
- interior = (x >= WIN-1) && (y >= WIN-1) at the anchor.
- Short lines (width below FRAME_WIDTH) work unchanged, because addressing restarts at hsync.
- Line longer than FRAME_WIDTH:
  - The address wraps modulo 2^ADDR_WIDTH and the affected data is undefined.
  - overrun sets on the en cycle where col reaches FRAME_WIDTH, and clears on the next vsync.
- hsync and vsync in the same cycle: vsync wins.
- Reset mid-frame: immediate return to the reset state. The next pixel is (0,0).

Decomposition:
- Shared package (global.vh additions):
  - WIN_MAX = 7.
  - COORD_WIDTH = 16.
  - Tap-index macro TAP(r,c,WIN) = (r*WIN+c).
- Sub-module line_delay (DATA_WIDTH, ADDR_WIDTH): single-port register-array row delay with read-before-write. Instantiated WIN-1 times in a generate loop.

Test Plan:
- WIN=3, line width 8, frame of 4 lines, data=row*16+col:
  - Pixel (2,2) -> window = {00,01,02,10,11,12,20,21,22} hex; interior=1; x=2; y=2.
  - Pixel (0,1) -> top row all 0, other rows' columns 0-1 = 0; tap(2,2)=10; interior=0.
- Back-to-back frames: vsync on frame 2 with the line memory full of frame-1 data -> every tap in rows above the anchor reads BORDER_VALUE (set to 8'hAA) during frame 2 row 0.
- en toggled 1/0/1 with random gaps -> valid pulses exactly once per en; window contents identical to the gap-free run.
- WIN=5, FRAME_WIDTH=16, line of 18 pixels -> overrun rises at col=16 and stays high until the next vsync, then returns to 0.
- Async reset asserted mid-line at col=5 -> all outputs 0 immediately. The next pixel after release reports x=0, y=0, interior=0.
- hsync and vsync asserted together with en -> row=0 and col=0; WIN=2 window top row = BORDER_VALUE.

Source files
------------

// File: rtl/sliding_window_buffer_pkg.sv
// Shared constants and helpers for the sliding-window neighbourhood buffer.
package sliding_window_buffer_pkg;

  localparam int unsigned WIN_MAX     = 7;
  localparam int unsigned COORD_WIDTH = 16;

  typedef logic [COORD_WIDTH-1:0] coord_t;

  // Flat tap index of row r, column c in a win x win window.
  function automatic int unsigned tap_idx(input int unsigned r, input int unsigned c,
                                          input int unsigned win);
    return r * win + c;
  endfunction

  function automatic coord_t sat_inc(input coord_t v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/sliding_window_buffer_line_delay.sv
// One raster-line delay: register-array memory addressed by column, read-before-write.
module line_delay
  import sliding_window_buffer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  // Combinational read sees the word before this cycle's write lands.
  assign rd_data = mem_q[addr];

  always_ff @(posedge clk) begin
    if (en) begin
      mem_q[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/sliding_window_buffer.sv
// WIN x WIN neighbourhood generator over a raster stream with position tracking and
// out-of-frame tap masking.
module sliding_window_buffer
  import sliding_window_buffer_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 8,
  parameter int unsigned           WIN          = 3,
  parameter int unsigned           FRAME_WIDTH  = 640,
  parameter int unsigned           ADDR_WIDTH   = 11,
  parameter logic [DATA_WIDTH-1:0] BORDER_VALUE = '0
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             en,
  input  logic                             hsync,
  input  logic                             vsync,
  input  logic [DATA_WIDTH-1:0]            data,
  output logic [WIN*WIN*DATA_WIDTH-1:0]    window,
  output logic                             valid,
  output logic                             interior,
  output logic [COORD_WIDTH-1:0]           x,
  output logic [COORD_WIDTH-1:0]           y,
  output logic                             overrun
);

  coord_t col_q, row_q, col_d, row_d;
  logic   first_q;

  logic [WIN-1:0][DATA_WIDTH-1:0]          stage_rd;
  logic [WIN-1:0][WIN-1:0][DATA_WIDTH-1:0] shreg_q, shreg_d;
  logic [WIN*WIN*DATA_WIDTH-1:0]           window_q, window_d;
  logic                                    valid_q, interior_q, interior_d, overrun_q;

  // Position of the pixel presented this cycle; the first pixel after reset is (0,0).
  always_comb begin
    col_d = sat_inc(col_q);
    row_d = row_q;
    if (vsync || first_q) begin
      col_d = '0;
      row_d = '0;
    end else if (hsync) begin
      col_d = '0;
      row_d = sat_inc(row_q);
    end
  end

  // stage_rd[k] is the same column k rows above; stage 0 is the live pixel.
  assign stage_rd[0] = data;

  for (genvar k = 1; k < WIN; k++) begin : g_stage
    line_delay #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_line_delay (
      .clk     (clk),
      .en      (en),
      .addr    (col_d[ADDR_WIDTH-1:0]),
      .wr_data (stage_rd[k-1]),
      .rd_data (stage_rd[k])
    );
  end

  always_comb begin
    shreg_d  = shreg_q;
    window_d = '0;
    for (int r = 0; r < WIN; r++) begin
      shreg_d[r] = {stage_rd[WIN-1-r], shreg_q[r][WIN-1:1]};
    end
    for (int r = 0; r < WIN; r++) begin
      for (int c = 0; c < WIN; c++) begin
        if (col_d < coord_t'(WIN - 1 - c) || row_d < coord_t'(WIN - 1 - r)) begin
          window_d[tap_idx(r, c, WIN)*DATA_WIDTH +: DATA_WIDTH] = BORDER_VALUE;
        end else begin
          window_d[tap_idx(r, c, WIN)*DATA_WIDTH +: DATA_WIDTH] = shreg_d[r][c];
        end
      end
    end
    interior_d = (col_d >= coord_t'(WIN - 1)) && (row_d >= coord_t'(WIN - 1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_q      <= '0;
      row_q      <= '0;
      first_q    <= 1'b1;
      shreg_q    <= '0;
      window_q   <= '0;
      valid_q    <= 1'b0;
      interior_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      valid_q <= en;
      if (en) begin
        col_q      <= col_d;
        row_q      <= row_d;
        first_q    <= 1'b0;
        shreg_q    <= shreg_d;
        window_q   <= window_d;
        interior_q <= interior_d;
        if (vsync) begin
          overrun_q <= 1'b0;
        end else if (32'(col_d) >= FRAME_WIDTH) begin
          overrun_q <= 1'b1;
        end
      end
    end
  end

  assign window   = window_q;
  assign valid    = valid_q;
  assign interior = interior_q;
  assign x        = col_q;
  assign y        = row_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_sliding_window_buffer.sv
// Bench for sliding_window_buffer: three parameterisations share one stimulus stream and are
// compared against a frame-array reference model.
module tb_sliding_window_buffer;
  import sliding_window_buffer_pkg::*;

  localparam int MW = WIN_MAX * WIN_MAX * 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0, hsync = 1'b0, vsync = 1'b0;
  logic [7:0]  data = '0;

  logic [71:0]  win3;
  logic [199:0] win5;
  logic [31:0]  win2;
  logic         valid3, valid5, valid2, int3, int5, int2, ov3, ov5, ov2;
  logic [15:0]  x3, y3, x5, y5, x2, y2;

  sliding_window_buffer #(
    .DATA_WIDTH(8), .WIN(3), .FRAME_WIDTH(640), .ADDR_WIDTH(11), .BORDER_VALUE(8'h00)
  ) u_dut3 (
    .clk(clk), .reset_n(reset_n), .en(en), .hsync(hsync), .vsync(vsync), .data(data),
    .window(win3), .valid(valid3), .interior(int3), .x(x3), .y(y3), .overrun(ov3)
  );

  sliding_window_buffer #(
    .DATA_WIDTH(8), .WIN(5), .FRAME_WIDTH(16), .ADDR_WIDTH(4), .BORDER_VALUE(8'hAA)
  ) u_dut5 (
    .clk(clk), .reset_n(reset_n), .en(en), .hsync(hsync), .vsync(vsync), .data(data),
    .window(win5), .valid(valid5), .interior(int5), .x(x5), .y(y5), .overrun(ov5)
  );

  sliding_window_buffer #(
    .DATA_WIDTH(8), .WIN(2), .FRAME_WIDTH(640), .ADDR_WIDTH(11), .BORDER_VALUE(8'h55)
  ) u_dut2 (
    .clk(clk), .reset_n(reset_n), .en(en), .hsync(hsync), .vsync(vsync), .data(data),
    .window(win2), .valid(valid2), .interior(int2), .x(x2), .y(y2), .overrun(ov2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: the current frame as a 2-D pixel array plus the anchor position.
  logic [7:0]    fr [64][64];
  int            mcol, mrow;
  bit            mfirst;
  bit            chk_w5;
  bit            gaps;
  logic [MW-1:0] e_w3, e_w5, e_w2;
  logic [15:0]   e_x, e_y;
  bit            e_v, e_i3, e_i5, e_i2, e_o3, e_o5, e_o2;

  task automatic chk(input string tag, input logic [MW-1:0] obs, input logic [MW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MW-1:0] exp_window(input int win, input logic [7:0] border);
    logic [MW-1:0] res;
    res = '0;
    for (int r = 0; r < win; r++) begin
      for (int c = 0; c < win; c++) begin
        int sr, sc;
        sr = mrow - (win - 1) + r;
        sc = mcol - (win - 1) + c;
        res[(r*win+c)*8 +: 8] = (sr < 0 || sc < 0) ? border : fr[sr][sc];
      end
    end
    return res;
  endfunction

  task automatic reset_model();
    mfirst = 1'b1;
    mcol = 0; mrow = 0;
    e_w3 = '0; e_w5 = '0; e_w2 = '0;
    e_x = '0; e_y = '0; e_v = 1'b0;
    e_i3 = 0; e_i5 = 0; e_i2 = 0;
    e_o3 = 0; e_o5 = 0; e_o2 = 0;
  endtask

  task automatic check_all();
    chk("valid3", MW'(valid3), MW'(e_v));
    chk("valid5", MW'(valid5), MW'(e_v));
    chk("valid2", MW'(valid2), MW'(e_v));
    chk("x3", MW'(x3), MW'(e_x));
    chk("y3", MW'(y3), MW'(e_y));
    chk("x5", MW'(x5), MW'(e_x));
    chk("y5", MW'(y5), MW'(e_y));
    chk("x2", MW'(x2), MW'(e_x));
    chk("y2", MW'(y2), MW'(e_y));
    chk("win3", MW'(win3), e_w3);
    if (chk_w5) chk("win5", MW'(win5), e_w5);
    chk("win2", MW'(win2), e_w2);
    if (e_v) begin
      chk("interior3", MW'(int3), MW'(e_i3));
      chk("interior5", MW'(int5), MW'(e_i5));
      chk("interior2", MW'(int2), MW'(e_i2));
    end
    chk("overrun3", MW'(ov3), MW'(e_o3));
    chk("overrun5", MW'(ov5), MW'(e_o5));
    chk("overrun2", MW'(ov2), MW'(e_o2));
  endtask

  task automatic step(input bit e, input bit hs, input bit vs, input logic [7:0] d);
    en = e; hsync = hs; vsync = vs; data = d;
    if (e) begin
      if (vs || mfirst) begin
        mcol = 0; mrow = 0;
        e_o3 = 0; e_o5 = 0; e_o2 = 0;
      end else if (hs) begin
        mcol = 0;
        if (mrow < 65535) mrow++;
      end else if (mcol < 65535) begin
        mcol++;
      end
      mfirst = 1'b0;
      if (mrow < 64 && mcol < 64) fr[mrow][mcol] = d;
      if (mcol >= 640) begin e_o3 = 1; e_o2 = 1; end
      if (mcol >= 16) e_o5 = 1;
      e_x = 16'(mcol);
      e_y = 16'(mrow);
      e_w3 = exp_window(3, 8'h00);
      e_w5 = exp_window(5, 8'hAA);
      e_w2 = exp_window(2, 8'h55);
      e_i3 = (mcol >= 2 && mrow >= 2);
      e_i5 = (mcol >= 4 && mrow >= 4);
      e_i2 = (mcol >= 1 && mrow >= 1);
    end
    e_v = e;
    @(posedge clk);
    #1;
    check_all();
  endtask

  // One accepted pixel, optionally preceded by idle cycles with junk sync/data.
  task automatic pix(input bit hs, input bit vs, input logic [7:0] d);
    if (gaps) begin
      repeat ($urandom_range(0, 2)) step(1'b0, 1'($urandom), 1'($urandom), 8'($urandom));
    end
    step(1'b1, hs, vs, d);
  endtask

  task automatic frame(input int rows, input int width);
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < width; c++) begin
        pix(r > 0 && c == 0, r == 0 && c == 0, 8'($urandom));
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset_model();
    chk_w5 = 1'b1;
    gaps = 1'b0;
    #12;
    check_all();
    reset_n = 1'b1;

    // Ramp frame: data = row*16 + col, first pixel carries no vsync.
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 8; c++) begin
        pix(r > 0 && c == 0, 1'b0, 8'(r * 16 + c));
        if (r == 1 && c == 0) begin
          chk("pix01_win3", MW'(win3), MW'(72'h100000000000000000));
          chk("pix01_int3", MW'(int3), MW'(1'b0));
        end
        if (r == 2 && c == 2) begin
          chk("pix22_win3", MW'(win3), MW'(72'h222120121110020100));
          chk("pix22_int3", MW'(int3), MW'(1'b1));
          chk("pix22_x3", MW'(x3), MW'(16'd2));
          chk("pix22_y3", MW'(y3), MW'(16'd2));
        end
      end
    end

    // Back-to-back frame with idle gaps; rows above the anchor must be border on row 0.
    gaps = 1'b1;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 8; c++) begin
        pix(r > 0 && c == 0, r == 0 && c == 0, 8'($urandom));
        if (r == 0) chk("f2_row0_above_win5", MW'(win5[159:0]), MW'({20{8'hAA}}));
      end
    end

    // hsync and vsync together: vsync wins.
    gaps = 1'b0;
    pix(1'b1, 1'b1, 8'($urandom));
    chk("hv_x2", MW'(x2), MW'(16'd0));
    chk("hv_y2", MW'(y2), MW'(16'd0));
    chk("hv_top_win2", MW'(win2[15:0]), MW'(16'h5555));
    for (int c = 1; c < 8; c++) pix(1'b0, 1'b0, 8'($urandom));
    for (int r = 1; r < 3; r++) begin
      for (int c = 0; c < 8; c++) pix(c == 0, 1'b0, 8'($urandom));
    end

    // Overlong line on the FRAME_WIDTH=16 instance.
    for (int c = 0; c < 18; c++) begin
      pix(1'b0, c == 0, 8'($urandom));
      if (c == 15) chk("ov5_col15", MW'(ov5), MW'(1'b0));
      if (c == 16) chk("ov5_col16", MW'(ov5), MW'(1'b1));
    end
    chk_w5 = 1'b0;
    for (int c = 0; c < 8; c++) pix(c == 0, 1'b0, 8'($urandom));
    chk("ov5_sticky", MW'(ov5), MW'(1'b1));
    chk_w5 = 1'b1;
    pix(1'b0, 1'b1, 8'($urandom));
    chk("ov5_cleared", MW'(ov5), MW'(1'b0));
    for (int c = 1; c < 8; c++) pix(1'b0, 1'b0, 8'($urandom));
    for (int r = 1; r < 6; r++) begin
      for (int c = 0; c < 8; c++) pix(c == 0, 1'b0, 8'($urandom));
    end

    // Reset in the middle of a line at col 5.
    frame(1, 8);
    for (int c = 0; c < 6; c++) pix(c == 0, 1'b0, 8'($urandom));
    #3;
    reset_n = 1'b0;
    #1;
    reset_model();
    check_all();
    #2;
    reset_n = 1'b1;
    pix(1'b0, 1'b0, 8'($urandom));
    chk("post_rst_x3", MW'(x3), MW'(16'd0));
    chk("post_rst_y3", MW'(y3), MW'(16'd0));
    chk("post_rst_int3", MW'(int3), MW'(1'b0));
    for (int c = 1; c < 8; c++) pix(1'b0, 1'b0, 8'($urandom));
    for (int r = 1; r < 6; r++) begin
      for (int c = 0; c < 8; c++) pix(c == 0, 1'b0, 8'($urandom));
    end

    // Random frames with gaps.
    gaps = 1'b1;
    frame(6, 8);
    frame(6, 8);
    gaps = 1'b0;
    step(1'b0, 1'b0, 1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
